// File: rtl/xlsu_defs.sv
// ============================================================================
// Package : xlsu_defs
// Shared encodings for the xlsu load/store unit: access sizes, FSM states
// and the byte-lane mask helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package xlsu_defs;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_e;

    // Byte-lane mask of an access of the given size, before lane alignment
    function automatic logic [7:0] size_mask(input size_e size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/xlsu_lane.sv
// ============================================================================
// Module  : xlsu_lane
// Combinational byte-lane steering for a 64-bit Wishbone data bus: byte
// selects, store data placement, load data right-justification and the
// natural-alignment check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xlsu_lane
    import xlsu_defs::*;
(
    input  size_e       size,
    input  logic [2:0]  off,
    input  logic [63:0] sdat,
    input  logic [63:0] rdat_in,
    output logic [7:0]  sel,
    output logic [63:0] wdat,
    output logic [63:0] ldat,
    output logic        misal
);

    logic [5:0] bit_off;

    assign bit_off = {off, 3'b000};

    // Lane placement and alignment check for the current size/offset
    always_comb begin
        sel  = size_mask(size) << off;
        wdat = sdat << bit_off;
        ldat = rdat_in >> bit_off;
        case (size)
            SZ_B:    misal = 1'b0;
            SZ_H:    misal = off[0];
            SZ_W:    misal = |off[1:0];
            default: misal = |off;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/xlsu.sv
// ============================================================================
// Module  : xlsu
// Load/store unit: one Wishbone classic cycle per request on a 64-bit
// byte-lane bus; loads write back through rd_o/rdat_o plus one strobe.
// Optional feature macro: XLSU_TIMEOUT_EN (bus timeout abort after
// TIMEOUT_CYCLES cycles without ack_i/err_i).
// Revision: 1.0
// ============================================================================
`default_nettype none

module xlsu
    import xlsu_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] sdat_i,
    input  logic [4:0]  rd_i,
    output logic        done_o,
    output logic        berr_o,
    output logic        misal_o,
    output logic [4:0]  rd_o,
    output logic [63:0] rdat_o,
    output logic        rzx8_o,
    output logic        rzx16_o,
    output logic        rzx32_o,
    output logic        rsx8_o,
    output logic        rsx16_o,
    output logic        rsx32_o,
    output logic        rsx64_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [63:0] adr_o,
    output logic [7:0]  sel_o,
    output logic [63:0] dat_o,
    input  logic [63:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i
);

    state_e     state;
    size_e      req_size;
    logic [2:0] req_off;
    logic       req_we;
    logic       req_uns;
    logic [4:0] req_rd;

    size_e      lane_size;
    logic [2:0] lane_off;
    logic [7:0] lane_sel;
    logic [63:0] lane_wdat;
    logic [63:0] lane_ldat;
    logic       lane_misal;
    logic       timeout;

    assign ready_o = (state == S_IDLE);

    // The lane block serves the incoming request while idle and the latched
    // request during the bus cycle, so a single instance suffices.
    assign lane_size = (state == S_IDLE) ? size_e'(size_i) : req_size;
    assign lane_off  = (state == S_IDLE) ? addr_i[2:0]     : req_off;

    xlsu_lane u_lane (
        .size    (lane_size),
        .off     (lane_off),
        .sdat    (sdat_i),
        .rdat_in (dat_i),
        .sel     (lane_sel),
        .wdat    (lane_wdat),
        .ldat    (lane_ldat),
        .misal   (lane_misal)
    );

`ifdef XLSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;

    // Count unterminated bus cycles; idle keeps it cleared for the next entry
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            to_cnt <= '0;
        end else if (state != S_BUS) begin
            to_cnt <= '0;
        end else if (!ack_i && !err_i) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // Abort on the edge that closes the TIMEOUT_CYCLES-th waiting bus cycle
    assign timeout = (state == S_BUS) && (to_cnt == CNT_LAST) && !ack_i && !err_i;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    // Request acceptance, Wishbone cycle control and write-back pulses
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= S_IDLE;
            req_size <= SZ_B;
            req_off  <= 3'd0;
            req_we   <= 1'b0;
            req_uns  <= 1'b0;
            req_rd   <= 5'd0;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            adr_o    <= 64'd0;
            sel_o    <= 8'd0;
            dat_o    <= 64'd0;
            done_o   <= 1'b0;
            berr_o   <= 1'b0;
            misal_o  <= 1'b0;
            rd_o     <= 5'd0;
            rdat_o   <= 64'd0;
            rzx8_o   <= 1'b0;
            rzx16_o  <= 1'b0;
            rzx32_o  <= 1'b0;
            rsx8_o   <= 1'b0;
            rsx16_o  <= 1'b0;
            rsx32_o  <= 1'b0;
            rsx64_o  <= 1'b0;
        end else begin
            // All status and write-back strobes are single-cycle pulses
            done_o  <= 1'b0;
            berr_o  <= 1'b0;
            misal_o <= 1'b0;
            rzx8_o  <= 1'b0;
            rzx16_o <= 1'b0;
            rzx32_o <= 1'b0;
            rsx8_o  <= 1'b0;
            rsx16_o <= 1'b0;
            rsx32_o <= 1'b0;
            rsx64_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        if (lane_misal) begin
                            misal_o <= 1'b1;
                        end else begin
                            state    <= S_BUS;
                            req_size <= size_e'(size_i);
                            req_off  <= addr_i[2:0];
                            req_we   <= we_i;
                            req_uns  <= uns_i;
                            req_rd   <= rd_i;
                            cyc_o    <= 1'b1;
                            stb_o    <= 1'b1;
                            we_o     <= we_i;
                            adr_o    <= {addr_i[63:3], 3'b000};
                            sel_o    <= lane_sel;
                            dat_o    <= we_i ? lane_wdat : 64'd0;
                        end
                    end
                end

                S_BUS: begin
                    if (err_i || timeout) begin
                        // Error takes priority over a simultaneous ack
                        state  <= S_IDLE;
                        cyc_o  <= 1'b0;
                        stb_o  <= 1'b0;
                        we_o   <= 1'b0;
                        sel_o  <= 8'd0;
                        dat_o  <= 64'd0;
                        berr_o <= 1'b1;
                    end else if (ack_i) begin
                        state  <= S_IDLE;
                        cyc_o  <= 1'b0;
                        stb_o  <= 1'b0;
                        we_o   <= 1'b0;
                        sel_o  <= 8'd0;
                        dat_o  <= 64'd0;
                        done_o <= 1'b1;
                        // x0 loads finish the bus cycle but never write back
                        if (!req_we && (req_rd != 5'd0)) begin
                            rd_o   <= req_rd;
                            rdat_o <= lane_ldat;
                            case (req_size)
                                SZ_B: begin
                                    rzx8_o <= req_uns;
                                    rsx8_o <= !req_uns;
                                end
                                SZ_H: begin
                                    rzx16_o <= req_uns;
                                    rsx16_o <= !req_uns;
                                end
                                SZ_W: begin
                                    rzx32_o <= req_uns;
                                    rsx32_o <= !req_uns;
                                end
                                default: begin
                                    rsx64_o <= 1'b1;
                                end
                            endcase
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
